// File: rtl/oc8051_fetch_defs.sv
// Shared definitions for the 8051 instruction-fetch front end: FSM encoding,
// fetch word geometry and the registered code-ROM request bundle.
package oc8051_fetch_defs;

    localparam int FQ_WORD_BYTES  = 4;
    localparam int FQ_MAX_CONSUME = 3;

    typedef enum logic [1:0] {
        FQ_IDLE    = 2'd0,
        FQ_REQ     = 2'd1,
        FQ_DISCARD = 2'd2
    } fq_state_t;

    typedef struct packed {
        logic        req;
        logic [15:0] addr;
    } fq_rom_req_t;

endpackage

// File: rtl/oc8051_byte_queue.sv
// DEPTH-byte circular buffer: 4-byte little-endian push, 0..3 byte pop,
// flush, occupancy count and a 3-byte peek window at the head.
module oc8051_byte_queue
    import oc8051_fetch_defs::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [31:0]   push_data,
    input  logic [1:0]    pop_cnt,
    output logic [CW-1:0] count,
    output logic [7:0]    peek0,
    output logic [7:0]    peek1,
    output logic [7:0]    peek2
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][7:0] mem;
    logic [AW-1:0]         head_q, tail_q;
    logic [CW-1:0]         cnt_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_q + AW'(pop_cnt);
            if (push)
                tail_q <= tail_q + AW'(FQ_WORD_BYTES);
            cnt_q <= cnt_q + (push ? CW'(FQ_WORD_BYTES) : '0) - CW'(pop_cnt);
        end
    end

    // Storage carries no reset; the count gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            for (int i = 0; i < FQ_WORD_BYTES; i++)
                mem[tail_q + AW'(i)] <= push_data[8*i +: 8];
        end
    end

    assign count = cnt_q;
    assign peek0 = (cnt_q > CW'(0)) ? mem[head_q]            : 8'h00;
    assign peek1 = (cnt_q > CW'(1)) ? mem[head_q + AW'(1)]   : 8'h00;
    assign peek2 = (cnt_q > CW'(2)) ? mem[head_q + AW'(2)]   : 8'h00;

endmodule

// File: rtl/oc8051_fetch_queue.sv
// 8051 instruction-fetch front end: code-ROM word requester feeding a byte queue.
// Optional FETCH_STATS_EN adds saturating stat_words / stat_flush counters.
module oc8051_fetch_queue
    import oc8051_fetch_defs::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pc_load,
    input  logic [15:0]   pc_in,
    input  logic [1:0]    consume,
    output logic          rom_req,
    output logic [15:0]   rom_addr,
    input  logic          rom_ack,
    input  logic [31:0]   rom_data,
    output logic          op_valid,
    output logic [7:0]    op0,
    output logic [7:0]    op1,
    output logic [7:0]    op2,
    output logic [CW-1:0] byte_cnt,
    output logic [15:0]   pc_out
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]   stat_words,
    output logic [15:0]   stat_flush
`endif
);

    fq_state_t     state_q, state_d;
    fq_rom_req_t   rom_q, rom_d;
    logic [15:0]   fptr_q, fptr_d;
    logic [15:0]   pc_q;
    logic [1:0]    pop_cnt;
    logic          push;
    logic [CW-1:0] cnt_after;
    logic          space_ok;

    // Over-long consume is dropped outright; a redirect overrides it too.
    assign pop_cnt   = (!pc_load && (CW'(consume) <= byte_cnt)) ? consume : 2'd0;
    assign push      = (state_q == FQ_REQ) && rom_ack && !pc_load;
    assign cnt_after = byte_cnt + CW'(FQ_WORD_BYTES) - CW'(pop_cnt);
    assign space_ok  = byte_cnt <= CW'(DEPTH - FQ_WORD_BYTES);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FQ_IDLE;
            rom_q   <= '0;
            fptr_q  <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            rom_q   <= rom_d;
            fptr_q  <= fptr_d;
            pc_q    <= pc_load ? pc_in : pc_q + 16'(pop_cnt);
        end
    end

    always_comb begin
        state_d = state_q;
        rom_d   = rom_q;
        fptr_d  = pc_load ? pc_in : fptr_q;
        unique case (state_q)
            FQ_IDLE: begin
                if (space_ok) begin
                    state_d    = FQ_REQ;
                    rom_d.req  = 1'b1;
                    rom_d.addr = pc_load ? pc_in : fptr_q;
                end
            end
            FQ_REQ: begin
                if (rom_ack) begin
                    if (pc_load) begin
                        state_d   = FQ_IDLE;
                        rom_d.req = 1'b0;
                    end else begin
                        fptr_d = fptr_q + 16'(FQ_WORD_BYTES);
                        if (cnt_after <= CW'(DEPTH - FQ_WORD_BYTES)) begin
                            rom_d.addr = fptr_q + 16'(FQ_WORD_BYTES);
                        end else begin
                            state_d   = FQ_IDLE;
                            rom_d.req = 1'b0;
                        end
                    end
                end else if (pc_load) begin
                    // Request already on the bus; wait out its ack and drop it.
                    state_d = FQ_DISCARD;
                end
            end
            FQ_DISCARD: begin
                if (rom_ack) begin
                    state_d   = FQ_IDLE;
                    rom_d.req = 1'b0;
                end
            end
            default: begin
                state_d = FQ_IDLE;
                rom_d   = '0;
            end
        endcase
    end

    oc8051_byte_queue #(.DEPTH(DEPTH), .CW(CW)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (pc_load),
        .push      (push),
        .push_data (rom_data),
        .pop_cnt   (pop_cnt),
        .count     (byte_cnt),
        .peek0     (op0),
        .peek1     (op1),
        .peek2     (op2)
    );

    assign rom_req  = rom_q.req;
    assign rom_addr = rom_q.addr;
    assign pc_out   = pc_q;
    assign op_valid = byte_cnt >= CW'(FQ_MAX_CONSUME);

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_words <= '0;
            stat_flush <= '0;
        end else begin
            if (push && stat_words != 16'hFFFF)
                stat_words <= stat_words + 16'd1;
            if (pc_load && stat_flush != 16'hFFFF)
                stat_flush <= stat_flush + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_oc8051_fetch_queue.sv
// Bench for oc8051_fetch_queue: directed spec scenarios plus random traffic
// against a byte-queue / outstanding-request reference model.
module tb_oc8051_fetch_queue;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          pc_load;
    logic [15:0]   pc_in;
    logic [1:0]    consume;
    logic          rom_req;
    logic [15:0]   rom_addr;
    logic          rom_ack;
    logic [31:0]   rom_data;
    logic          op_valid;
    logic [7:0]    op0, op1, op2;
    logic [CW-1:0] byte_cnt;
    logic [15:0]   pc_out;
`ifdef FETCH_STATS_EN
    logic [15:0]   stat_words, stat_flush;
`endif

    oc8051_fetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .pc_load  (pc_load),
        .pc_in    (pc_in),
        .consume  (consume),
        .rom_req  (rom_req),
        .rom_addr (rom_addr),
        .rom_ack  (rom_ack),
        .rom_data (rom_data),
        .op_valid (op_valid),
        .op0      (op0),
        .op1      (op1),
        .op2      (op2),
        .byte_cnt (byte_cnt),
        .pc_out   (pc_out)
`ifdef FETCH_STATS_EN
        ,
        .stat_words (stat_words),
        .stat_flush (stat_flush)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference: byte queue, one outstanding request and whether its data is stale.
    logic [7:0]  mq[$];
    bit          m_req, m_stale;
    logic [15:0] m_addr, m_fptr, m_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit ld, input logic [15:0] pin,
                              input logic [1:0] cons, input bit ack, input logic [31:0] data);
        int cnt;
        bit push;
        cnt = mq.size();
        if (r) begin
            mq.delete();
            m_req = 0; m_stale = 0; m_addr = 0; m_fptr = 0; m_pc = 0;
            return;
        end
        push = 0;
        if (!m_req) begin
            if (DEPTH - cnt >= 4) begin
                m_req  = 1;
                m_addr = ld ? pin : m_fptr;
            end
        end else if (ack) begin
            if (m_stale || ld) begin
                m_req = 0; m_stale = 0;
            end else begin
                push = 1;
            end
        end else if (ld) begin
            m_stale = 1;
        end
        if (ld) begin
            mq.delete();
            m_fptr = pin;
            m_pc   = pin;
        end else begin
            if (int'(cons) <= cnt) begin
                for (int k = 0; k < int'(cons); k++) void'(mq.pop_front());
                m_pc = m_pc + 16'(cons);
            end
            if (push) begin
                for (int k = 0; k < 4; k++) mq.push_back(data[8*k +: 8]);
                m_fptr = m_addr + 16'd4;
                if (DEPTH - mq.size() >= 4) m_addr = m_addr + 16'd4;
                else m_req = 0;
            end
        end
    endtask

    function automatic logic [7:0] mbyte(input int k);
        return (mq.size() > k) ? mq[k] : 8'h00;
    endfunction

    task automatic cmp_model();
        chk("rom_req",  32'(rom_req),  32'(m_req));
        chk("rom_addr", 32'(rom_addr), 32'(m_addr));
        chk("pc_out",   32'(pc_out),   32'(m_pc));
        chk("byte_cnt", 32'(byte_cnt), 32'(mq.size()));
        chk("op_valid", 32'(op_valid), 32'(mq.size() >= 3));
        chk("op0",      32'(op0),      32'(mbyte(0)));
        chk("op1",      32'(op1),      32'(mbyte(1)));
        chk("op2",      32'(op2),      32'(mbyte(2)));
    endtask

    task automatic step(input bit r, input bit ld, input logic [15:0] pin,
                        input logic [1:0] cons, input bit ack, input logic [31:0] data);
        @(negedge clk);
        rst = r; pc_load = ld; pc_in = pin; consume = cons; rom_ack = ack; rom_data = data;
        @(posedge clk);
        model_step(r, ld, pin, cons, ack, data);
        #1 cmp_model();
    endtask

    initial begin
        rst = 1; pc_load = 0; pc_in = 0; consume = 0; rom_ack = 0; rom_data = 0;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_req", 32'(rom_req), 0);
        chk("rst_cnt", 32'(byte_cnt), 0);
        chk("rst_pc",  32'(pc_out), 0);

        step(0, 1, 16'h0100, 0, 0, 0);
        chk("ld_req",  32'(rom_req), 1);
        chk("ld_addr", 32'(rom_addr), 32'h0100);
        step(0, 0, 0, 0, 0, 0);
        chk("hold_addr", 32'(rom_addr), 32'h0100);
        step(0, 0, 0, 0, 1, 32'h44332211);
        chk("ack_op0", 32'(op0), 32'h11);
        chk("ack_op1", 32'(op1), 32'h22);
        chk("ack_op2", 32'(op2), 32'h33);
        chk("ack_cnt", 32'(byte_cnt), 4);
        chk("ack_pc",  32'(pc_out), 32'h0100);
        step(0, 0, 0, 3, 1, 32'h88776655);
        chk("pp_cnt", 32'(byte_cnt), 5);
        chk("pp_op0", 32'(op0), 32'h44);
        chk("pp_op1", 32'(op1), 32'h55);
        chk("pp_pc",  32'(pc_out), 32'h0103);

        step(0, 1, 16'h0200, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("req200", 32'(rom_addr), 32'h0200);
        step(0, 1, 16'h0300, 0, 0, 0);
        chk("disc_hold", 32'(rom_addr), 32'h0200);
        step(0, 0, 0, 0, 1, 32'hDEADBEEF);
        chk("disc_drop_cnt", 32'(byte_cnt), 0);
        chk("disc_req", 32'(rom_req), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("req300", 32'(rom_addr), 32'h0300);

        step(0, 0, 0, 0, 1, 32'h03020100);
        step(0, 0, 0, 0, 1, 32'h07060504);
        step(0, 0, 0, 0, 0, 0);
        chk("full_req", 32'(rom_req), 0);
        chk("full_cnt", 32'(byte_cnt), 8);
        step(0, 0, 0, 2, 0, 0);
        chk("c2_cnt", 32'(byte_cnt), 6);
        step(0, 0, 0, 2, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("refill_req", 32'(rom_req), 1);
        step(0, 0, 0, 3, 0, 0);
        chk("overcons_cnt", 32'(byte_cnt), 1);
        step(0, 0, 0, 3, 0, 0);
        chk("ignored_cnt", 32'(byte_cnt), 1);

        step(0, 1, 16'hFFFE, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h0);
        step(0, 0, 0, 0, 0, 0);
        chk("wrap_a0", 32'(rom_addr), 32'hFFFE);
        step(0, 0, 0, 0, 1, 32'hA3A2A1A0);
        chk("wrap_a1", 32'(rom_addr), 32'h0002);
        step(0, 0, 0, 2, 0, 0);
        chk("wrap_pc", 32'(pc_out), 32'h0000);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 11) == 0,
                 16'($urandom),
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 9) < 4,
                 $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
